// File: rtl/keyb_scan_ctrl_if.sv
// Keypad scan controller bundle: matrix lines toward the keypad and the key strobe toward
// the calculator FSM. The controller side uses the master modport.
interface keyb_scan_ctrl_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/keyb_scan_ctrl.sv
// 4x4 keypad scanner with one shared debounce counter and a one-cycle key strobe.
// Optional auto-repeat while a key is held: define KEYB_REPEAT_EN.
module keyb_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter int unsigned REPEAT_DLY   = 25000000,
  parameter int unsigned REPEAT_PER   = 10000000
) (
  input  logic              clk,
  input  logic              reset,
  keyb_scan_ctrl_if.master  kb
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DbW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
  localparam logic [DbW-1:0]  DbMax  = DbW'(DEBOUNCE_CYC - 1);

  if (SCAN_DIV == 0 || DEBOUNCE_CYC == 0 || REPEAT_DLY == 0 || REPEAT_PER == 0) begin : g_bad_params
    $error("keyb_scan_ctrl: all timing parameters must be non-zero");
  end

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e          state_q;
  logic [3:0]      row_meta_q;
  logic [3:0]      row_s_q;
  logic [3:0]      row_cap_q;
  logic [1:0]      col_idx_q;
  logic [3:0]      col_n_q;
  logic [DivW-1:0] div_cnt_q;
  logic [DbW-1:0]  db_cnt_q;
  logic [3:0]      key_code_q;
  logic            key_valid_q;
  logic            key_down_q;

`ifdef KEYB_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;
  localparam logic [RepW-1:0] RepDlyMax = RepW'(REPEAT_DLY - 1);
  localparam logic [RepW-1:0] RepPerMax = RepW'(REPEAT_PER - 1);

  logic [RepW-1:0] rep_cnt_q;
  // Set once the first (long) repeat delay has elapsed; later repeats use the period.
  logic            rep_periodic_q;
`endif

  // Lowest row index pulled low wins when several rows are active.
  function automatic logic [1:0] row_prio(input logic [3:0] rows);
    if (!rows[0])      row_prio = 2'd0;
    else if (!rows[1]) row_prio = 2'd1;
    else if (!rows[2]) row_prio = 2'd2;
    else               row_prio = 2'd3;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    col_drive = ~(4'b0001 << idx);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StScan;
      row_meta_q  <= 4'hF;
      row_s_q     <= 4'hF;
      row_cap_q   <= 4'hF;
      col_idx_q   <= 2'd0;
      col_n_q     <= 4'b1110;
      div_cnt_q   <= '0;
      db_cnt_q    <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
`ifdef KEYB_REPEAT_EN
      rep_cnt_q      <= '0;
      rep_periodic_q <= 1'b0;
`endif
    end else begin
      row_meta_q  <= kb.row_n;
      row_s_q     <= row_meta_q;
      key_valid_q <= 1'b0;

      unique case (state_q)
        StScan: begin
          if (div_cnt_q == DivMax) begin
            div_cnt_q <= '0;
            if (row_s_q == 4'hF) begin
              col_idx_q <= col_idx_q + 2'd1;
              col_n_q   <= col_drive(col_idx_q + 2'd1);
            end else begin
              row_cap_q <= row_s_q;
              db_cnt_q  <= '0;
              state_q   <= StDebounce;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end

        StDebounce: begin
          if (row_s_q != row_cap_q) begin
            div_cnt_q <= '0;
            state_q   <= StScan;
          end else if (db_cnt_q == DbMax) begin
            key_code_q  <= {row_prio(row_cap_q), col_idx_q};
            key_valid_q <= 1'b1;
            key_down_q  <= 1'b1;
            db_cnt_q    <= '0;
            state_q     <= StHeld;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end

        StHeld: begin
          // Column stays frozen; a different non-idle pattern is deliberately ignored.
          if (row_s_q == 4'hF) begin
            db_cnt_q <= '0;
            state_q  <= StRelease;
`ifdef KEYB_REPEAT_EN
            rep_cnt_q      <= '0;
            rep_periodic_q <= 1'b0;
          end else if (rep_cnt_q == (rep_periodic_q ? RepPerMax : RepDlyMax)) begin
            key_valid_q    <= 1'b1;
            rep_cnt_q      <= '0;
            rep_periodic_q <= 1'b1;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
`endif
          end
        end

        StRelease: begin
          if (row_s_q != 4'hF) begin
            state_q <= StHeld;
          end else if (db_cnt_q == DbMax) begin
            key_down_q <= 1'b0;
            div_cnt_q  <= '0;
            col_idx_q  <= col_idx_q + 2'd1;
            col_n_q    <= col_drive(col_idx_q + 2'd1);
            state_q    <= StScan;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end

        default: state_q <= StScan;
      endcase
    end
  end

  assign kb.col_n     = col_n_q;
  assign kb.key_code  = key_code_q;
  assign kb.key_valid = key_valid_q;
  assign kb.key_down  = key_down_q;

endmodule

// File: tb/tb_keyb_scan_ctrl.sv
// Directed bench for keyb_scan_ctrl with a behavioural 4x4 key matrix model.
// Define KEYB_REPEAT_EN for both bench and RTL to exercise auto-repeat.
module tb_keyb_scan_ctrl;

  localparam int unsigned ScanDiv = 4;
  localparam int unsigned DebCyc  = 16;
  localparam int unsigned RepDly  = 64;
  localparam int unsigned RepPer  = 32;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] keys  = '0;
  logic [3:0]  row_model;

  int          tests      = 0;
  int          fails      = 0;
  int          cyc        = 0;
  int          strobe_cnt = 0;
  int          b2b_cnt    = 0;
  logic        prev_valid = 1'b0;
  logic [3:0]  last_code  = 4'd0;
  int          stamps[32];

  keyb_scan_ctrl_if kb ();

  keyb_scan_ctrl #(
    .SCAN_DIV    (ScanDiv),
    .DEBOUNCE_CYC(DebCyc),
    .REPEAT_DLY  (RepDly),
    .REPEAT_PER  (RepPer)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .kb   (kb)
  );

  always #5 clk = ~clk;

  // Key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !kb.col_n[c]) row_model[r] = 1'b0;
      end
    end
  end
  assign kb.row_n = row_model;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (kb.key_valid === 1'b1) begin
      if (strobe_cnt < 32) stamps[strobe_cnt] = cyc;
      strobe_cnt = strobe_cnt + 1;
      last_code  = kb.key_code;
      if (prev_valid) b2b_cnt = b2b_cnt + 1;
    end
    prev_valid = (kb.key_valid === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_key_up(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (kb.key_down === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  base;
    bit  seen;
    int  rep_exp[6];
    rep_exp = '{0, 64, 96, 128, 160, 192};

    // Reset state
    cycles(3);
    check("rst_col_n", 32'(kb.col_n), 32'h0000000E);
    check("rst_key_code", 32'(kb.key_code), 32'd0);
    check("rst_key_valid", 32'(kb.key_valid), 32'd0);
    check("rst_key_down", 32'(kb.key_down), 32'd0);
    reset = 1'b0;

    // Steady press of (2,1), then release
    base = strobe_cnt;
    keys[9] = 1'b1;
    cycles(200);
`ifdef KEYB_REPEAT_EN
    check("t1_strobes_min", 32'(strobe_cnt - base >= 1), 32'd1);
`else
    check("t1_strobes", 32'(strobe_cnt - base), 32'd1);
`endif
    check("t1_code", 32'(last_code), 32'd9);
    check("t1_key_down_held", 32'(kb.key_down), 32'd1);
    check("t1_col_frozen", 32'(kb.col_n), 32'h0000000D);
    keys = '0;
    wait_key_up(seen);
    check("t1_release_seen", 32'(seen), 32'd1);
    check("t1_col_after_release", 32'(kb.col_n), 32'h0000000B);
    cycles(4);
    check("t1_col_rotates", 32'(kb.col_n), 32'h00000007);

    // Bouncy press of (0,3), bouncy release
    base = strobe_cnt;
    keys[3] = 1'b1; cycles(3);
    keys[3] = 1'b0; cycles(3);
    keys[3] = 1'b1; cycles(5);
    keys[3] = 1'b0; cycles(4);
    keys[3] = 1'b1; cycles(2);
    keys[3] = 1'b0; cycles(3);
    check("t2_no_bounce_strobe", 32'(strobe_cnt - base), 32'd0);
    keys[3] = 1'b1; cycles(60);
    check("t2_strobes", 32'(strobe_cnt - base), 32'd1);
    check("t2_code", 32'(last_code), 32'd3);
    keys[3] = 1'b0; cycles(2);
    keys[3] = 1'b1; cycles(4);
    keys[3] = 1'b0; cycles(60);
    check("t2_no_release_strobe", 32'(strobe_cnt - base), 32'd1);
    check("t2_key_down_low", 32'(kb.key_down), 32'd0);

    // Ghosted pair in column 2: row 1 wins
    base = strobe_cnt;
    keys[6] = 1'b1; keys[14] = 1'b1;
    cycles(60);
    check("t3_strobes", 32'(strobe_cnt - base), 32'd1);
    check("t3_code", 32'(last_code), 32'd6);
    keys = '0; cycles(60);

    // Press (3,0) twice with a 30-cycle gap
    base = strobe_cnt;
    keys[12] = 1'b1; cycles(60);
    keys[12] = 1'b0; cycles(30);
    keys[12] = 1'b1; cycles(60);
    keys[12] = 1'b0; cycles(60);
    check("t4_strobes", 32'(strobe_cnt - base), 32'd2);
    check("t4_code", 32'(last_code), 32'd12);

    // One-cycle reset in the middle of qualifying (2,1)
    base = strobe_cnt;
    keys[9] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (kb.row_n !== 4'hF) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_row_low_seen", 32'(seen), 32'd1);
    cycles(8);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    keys  = '0;
    check("t5_col_n", 32'(kb.col_n), 32'h0000000E);
    check("t5_key_code", 32'(kb.key_code), 32'd0);
    check("t5_key_down", 32'(kb.key_down), 32'd0);
    check("t5_key_valid", 32'(kb.key_valid), 32'd0);
    cycles(4);
    check("t5_scan_restart", 32'(kb.col_n), 32'h0000000D);
    cycles(40);
    check("t5_no_strobe", 32'(strobe_cnt - base), 32'd0);

    // Long hold of (1,1)
    base = strobe_cnt;
    keys[5] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (strobe_cnt > base) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_first_strobe", 32'(seen), 32'd1);
    cycles(200);
    keys = '0;
    cycles(60);
    check("t6_code", 32'(last_code), 32'd5);
`ifdef KEYB_REPEAT_EN
    check("t6_strobes", 32'(strobe_cnt - base), 32'd6);
    for (int k = 1; k < 6; k++) begin
      check($sformatf("t6_rep%0d_offset", k), 32'(stamps[base+k] - stamps[base]), 32'(rep_exp[k]));
    end
`else
    check("t6_strobes", 32'(strobe_cnt - base), 32'd1);
`endif

    check("no_back_to_back", 32'(b2b_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
